// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGo,
        StAck,
        StDone
    } sched_state_e;

    // I/O port addresses (io_addr is a single bit).
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    // Status register bit positions.
    localparam int unsigned STAT_OVF_BIT   = 7;
    localparam int unsigned STAT_FULL_BIT  = 6;
    localparam int unsigned STAT_EMPTY_BIT = 5;
    localparam int unsigned STAT_BUSY_BIT  = 4;
    localparam int unsigned STAT_CNT_W     = 4;

    // Assemble the status byte; cnt is already saturated to 4 bits.
    function automatic logic [7:0] pack_status(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic [3:0] cnt
    );
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_BUSY_BIT]  = busy;
        s[STAT_CNT_W-1:0] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// CPU I/O bus and UART core handshake bundle for the transmit scheduler.
interface uart_tx_sched_if;
    logic       io_we;
    logic       io_re;
    logic       io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic [7:0] uart_data;
    logic       uart_go;
    logic       uart_busy;

    // Host side: drives the I/O strobes and reports UART core busy.
    modport master (
        output io_we, io_re, io_addr, io_wdata, uart_busy,
        input  io_rdata, uart_data, uart_go
    );

    // Scheduler side.
    modport slave (
        input  io_we, io_re, io_addr, io_wdata, uart_busy,
        output io_rdata, uart_data, uart_go
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible combinationally.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Pointer and count next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: buffers CPU data-port writes and feeds them to the
// UART core one byte at a time over a go/busy handshake, with a pollable status port.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_sched_if.slave   bus,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             overflow
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    sched_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    uart_data_q, uart_data_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          overflow_q, overflow_d;
    logic          go;

    logic          wr_data;
    logic          rd_stat;
    logic          fifo_push;
    logic          fifo_pop;
    logic          ovf_event;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [8:0]    count_ext;
    logic [3:0]    count_sat;
    logic [7:0]    status;

    assign wr_data   = bus.io_we && (bus.io_addr == ADDR_DATA);
    assign rd_stat   = bus.io_re && (bus.io_addr == ADDR_STAT);
    assign fifo_push = wr_data;
    assign fifo_pop  = (state_q == StLoad);
    // A write that the FIFO cannot take, even counting a same-cycle pop.
    assign ovf_event = wr_data && fifo_full && !fifo_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.io_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign count_ext = 9'(fifo_count);
    assign count_sat = (count_ext > 9'd15) ? 4'hF : count_ext[3:0];
    assign status    = pack_status(overflow_q, fifo_full, fifo_empty,
                                   (state_q != StIdle), count_sat);

    // Scheduler next-state, handshake timer and byte latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        uart_data_d = uart_data_q;
        go          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !bus.uart_busy) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                uart_data_d = fifo_rdata;
                state_d     = StGo;
            end
            StGo: begin
                go      = 1'b1;
                timer_d = '0;
                state_d = StAck;
            end
            StAck: begin
                if (bus.uart_busy) begin
                    state_d = StDone;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Core never acknowledged: drop the byte and move on.
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StDone: begin
                if (!bus.uart_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data and sticky overflow next-state; a new overflow beats a clearing read.
    always_comb begin
        rdata_d    = rdata_q;
        overflow_d = overflow_q;
        if (bus.io_re) begin
            rdata_d = rd_stat ? status : 8'h00;
        end
        if (rd_stat) begin
            overflow_d = 1'b0;
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end
    end

    // State, timer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            uart_data_q <= 8'h00;
            rdata_q     <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            uart_data_q <= uart_data_d;
            rdata_q     <= rdata_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.io_rdata  = rdata_q;
    assign bus.uart_data = uart_data_q;
    assign bus.uart_go   = go;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a simple UART core model.
module tb_uart_tx_sched;
    import uart_sched_pkg::*;

    typedef struct {
        bit         we;
        bit         re;
        bit         addr;
        logic [7:0] wdata;
        bit         chk_rd;
        logic [7:0] exp_rd;
        bit         exp_full;
        bit         exp_empty;
        bit         exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic fifo_full, fifo_empty, overflow;

    uart_tx_sched_if bus ();

    uart_tx_sched #(
        .DEPTH       (16),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    // UART core model: raises busy the cycle after go and holds it busy_len cycles.
    logic busy_hold = 1'b0;
    logic ack_en    = 1'b0;
    logic model_clr = 1'b0;
    int   busy_len  = 1;
    int   busy_cnt  = 0;

    always @(posedge clk) begin
        if (model_clr) busy_cnt <= 0;
        else if (bus.uart_go && ack_en) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.uart_busy = busy_hold || (busy_cnt > 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every go pulse and the cycle busy last fell, sampled mid-cycle.
    logic [7:0] go_data[$];
    int         go_cyc[$];
    logic       busy_prev = 1'b0;
    int         last_fall = 0;
    always @(negedge clk) begin
        if (bus.uart_go) begin
            go_data.push_back(bus.uart_data);
            go_cyc.push_back(cyc);
        end
        if (busy_prev && !bus.uart_busy) last_fall <= cyc;
        busy_prev <= bus.uart_busy;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input bit we, input bit re, input bit addr, input logic [7:0] wd);
        bus.io_we    = we;
        bus.io_re    = re;
        bus.io_addr  = addr;
        bus.io_wdata = wd;
        tick();
        bus.io_we    = 1'b0;
        bus.io_re    = 1'b0;
        bus.io_addr  = 1'b0;
        bus.io_wdata = 8'h00;
    endtask

    task automatic read_status(input string name, input logic [7:0] exp);
        bus_op(1'b0, 1'b1, ADDR_STAT, 8'h00);
        check(name, bus.io_rdata, exp);
    endtask

    task automatic do_reset();
        bus.io_we    = 1'b0;
        bus.io_re    = 1'b0;
        bus.io_addr  = 1'b0;
        bus.io_wdata = 8'h00;
        busy_hold    = 1'b0;
        ack_en       = 1'b0;
        reset        = 1'b1;
        model_clr    = 1'b1;
        tick();
        tick();
        reset        = 1'b0;
        model_clr    = 1'b0;
        go_data.delete();
        go_cyc.delete();
    endtask

    // Bounded wait for the next logged go pulse; a timeout counts as a failed check.
    task automatic wait_go(input string name, input int limit,
                           output logic [7:0] d, output int c);
        bit ok;
        ok = 1'b0;
        d  = 8'hxx;
        c  = -1000;
        for (int i = 0; i < limit; i++) begin
            if (go_data.size() > 0) break;
            tick();
        end
        if (go_data.size() > 0) begin
            d  = go_data.pop_front();
            c  = go_cyc.pop_front();
            ok = 1'b1;
        end
        check({name, " go seen"}, 32'(ok), 32'd1);
    endtask

    function automatic vec_t mk(input bit we, input bit re, input bit addr, input logic [7:0] wd,
                                input bit chk, input logic [7:0] rd,
                                input bit f, input bit e, input bit o);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wd;
        v.chk_rd = chk; v.exp_rd = rd;
        v.exp_full = f; v.exp_empty = e; v.exp_ovf = o;
        return v;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[$];
        logic [7:0] d;
        int         c, c0, wr_c;

        // ---- Test 1: reset state and single byte latency ----
        do_reset();
        check("rst io_rdata", bus.io_rdata, 8'h00);
        check("rst uart_data", bus.uart_data, 8'h00);
        check("rst uart_go", bus.uart_go, 1'b0);
        check("rst fifo_empty", fifo_empty, 1'b1);
        check("rst fifo_full", fifo_full, 1'b0);
        check("rst overflow", overflow, 1'b0);
        read_status("rst status", 8'h20);

        ack_en   = 1'b1;
        busy_len = 20;
        wr_c     = cyc;
        bus_op(1'b1, 1'b0, ADDR_DATA, 8'h41);
        wait_go("t1", 20, d, c);
        check("t1 go latency", 32'(c - wr_c), 32'd3);
        check("t1 uart_data", d, 8'h41);
        tick();
        check("t1 single go pulse", 32'(go_data.size()), 32'd0);
        for (int i = 0; i < 30; i++) tick();
        read_status("t1 status idle", 8'h20);
        check("t1 uart_data held", bus.uart_data, 8'h41);

        // ---- Tests 2/3: fill while busy held, overflow, status port behaviour ----
        do_reset();
        busy_hold = 1'b1;
        ack_en    = 1'b1;
        busy_len  = 3;
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(1, 0, 0, 8'(i), 0, 8'h00, (i == 15), 0, 0));
        end
        vecs.push_back(mk(1, 0, 0, 8'hEE, 0, 8'h00, 1, 0, 1));  // 17th write dropped
        vecs.push_back(mk(0, 1, 1, 8'h00, 1, 8'hCF, 1, 0, 0));  // shows then clears overflow
        vecs.push_back(mk(0, 1, 1, 8'h00, 1, 8'h4F, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 1, 0, 0));  // data-port read
        vecs.push_back(mk(1, 0, 1, 8'h77, 1, 8'h00, 1, 0, 0));  // status write ignored
        vecs.push_back(mk(0, 1, 1, 8'h00, 1, 8'h4F, 1, 0, 0));
        foreach (vecs[i]) begin
            bus_op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d full", i), fifo_full, vecs[i].exp_full);
            check($sformatf("vec%0d empty", i), fifo_empty, vecs[i].exp_empty);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
            if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), bus.io_rdata, vecs[i].exp_rd);
        end
        check("t2 no go while busy", 32'(go_data.size()), 32'd0);

        busy_hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_go($sformatf("t2 byte%0d", i), 60, d, c);
            check($sformatf("t2 byte%0d data", i), d, 8'(i));
            check($sformatf("t2 byte%0d spacing ok", i), 32'(c - last_fall >= 2), 32'd1);
        end
        for (int i = 0; i < 40; i++) tick();
        check("t2 dropped byte not sent", 32'(go_data.size()), 32'd0);
        check("t2 drained empty", fifo_empty, 1'b1);

        // ---- Test 4: ack timeout abandons the byte ----
        do_reset();
        ack_en = 1'b0;
        bus_op(1'b1, 1'b0, ADDR_DATA, 8'h55);
        bus_op(1'b1, 1'b0, ADDR_DATA, 8'h66);
        wait_go("t4 first", 20, d, c0);
        check("t4 first data", d, 8'h55);
        tick();
        read_status("t4 status in ack", 8'h11);
        wait_go("t4 second", 100, d, c);
        check("t4 second data", d, 8'h66);
        check("t4 timeout spacing", 32'(c - c0), 32'd67);
        for (int i = 0; i < 80; i++) tick();
        read_status("t4 status after", 8'h20);

        // ---- Test 5: reset during DONE with bytes queued ----
        do_reset();
        ack_en   = 1'b1;
        busy_len = 40;
        for (int i = 0; i < 6; i++) bus_op(1'b1, 1'b0, ADDR_DATA, 8'h81 + 8'(i));
        wait_go("t5", 20, d, c);
        check("t5 first data", d, 8'h81);
        for (int i = 0; i < 5; i++) tick();
        read_status("t5 status in done", 8'h15);
        reset = 1'b1;
        tick();
        check("t5 io_rdata", bus.io_rdata, 8'h00);
        check("t5 uart_data", bus.uart_data, 8'h00);
        check("t5 uart_go", bus.uart_go, 1'b0);
        check("t5 fifo_empty", fifo_empty, 1'b1);
        check("t5 fifo_full", fifo_full, 1'b0);
        check("t5 overflow", overflow, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("t5 no further go", 32'(go_data.size()), 32'd0);

        // ---- Test 6: write into full FIFO in the same cycle as the LOAD pop ----
        do_reset();
        busy_hold = 1'b1;
        ack_en    = 1'b1;
        busy_len  = 2;
        for (int i = 0; i < 16; i++) bus_op(1'b1, 1'b0, ADDR_DATA, 8'h10 + 8'(i));
        check("t6 full before", fifo_full, 1'b1);
        busy_hold = 1'b0;
        tick();
        bus_op(1'b1, 1'b0, ADDR_DATA, 8'hAA);
        check("t6 full after", fifo_full, 1'b1);
        check("t6 overflow stays 0", overflow, 1'b0);
        read_status("t6 status", 8'h5F);
        for (int i = 0; i < 17; i++) begin
            wait_go($sformatf("t6 byte%0d", i), 60, d, c);
            check($sformatf("t6 byte%0d data", i), d, (i < 16) ? 8'h10 + 8'(i) : 8'hAA);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
